// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encoding and default multiply/divide latencies.
package mdu_pkg;

   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MTHI  = 4'd5,
      MDU_MTLO  = 4'd6
   } mdu_op_e;

   localparam int unsigned MDU_MULT_CYCLES = 5;
   localparam int unsigned MDU_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu.sv
// MIPS E-stage multiply/divide unit owning HI/LO; results are computed at issue
// and committed after a fixed latency while Busy stalls dependent instructions.
module mdu
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
   parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MDUOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Start,
   input  logic        Req,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   mdu_op_e            op;
   logic               idle_ok;
   logic               issue;
   logic               res_wr;
   logic [31:0]        res_hi;
   logic [31:0]        res_lo;
   logic [3:0]         res_cnt;
   logic signed [63:0] sa;
   logic signed [63:0] sb;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        bd;

   logic [3:0]  cnt;
   logic        pend_wr;
   logic [31:0] pend_hi;
   logic [31:0] pend_lo;

   always_comb begin
      op      = mdu_op_e'(MDUOp);
      idle_ok = !Req && !Busy;
      sa      = {{32{A[31]}}, A};
      sb      = {{32{B[31]}}, B};
      prod_s  = sa * sb;
      prod_u  = {32'b0, A} * {32'b0, B};
      // divisor forced nonzero so the unused quotient stays defined; the write is suppressed anyway
      bd      = (B == '0) ? 32'd1 : B;
      res_wr  = 1'b1;
      res_hi  = '0;
      res_lo  = '0;
      res_cnt = 4'(MULT_CYCLES);
      issue   = 1'b0;
      case (op)
         MDU_MULT: begin
            issue  = Start && idle_ok;
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         MDU_MULTU: begin
            issue  = Start && idle_ok;
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         MDU_DIV: begin
            issue   = Start && idle_ok;
            res_cnt = 4'(DIV_CYCLES);
            res_wr  = (B != '0);
            if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
               res_lo = 32'h8000_0000;
               res_hi = '0;
            end else begin
               res_lo = $signed(A) / $signed(bd);
               res_hi = $signed(A) % $signed(bd);
            end
         end
         MDU_DIVU: begin
            issue   = Start && idle_ok;
            res_cnt = 4'(DIV_CYCLES);
            res_wr  = (B != '0);
            res_lo  = A / bd;
            res_hi  = A % bd;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         Busy    <= 1'b0;
         pend_wr <= 1'b0;
         pend_hi <= '0;
         pend_lo <= '0;
         HI      <= '0;
         LO      <= '0;
      end else if (cnt != '0) begin
         cnt <= cnt - 4'd1;
         if (cnt == 4'd1) begin
            Busy <= 1'b0;
            if (pend_wr) begin
               HI <= pend_hi;
               LO <= pend_lo;
            end
         end
      end else if (issue) begin
         cnt     <= res_cnt;
         Busy    <= 1'b1;
         pend_wr <= res_wr;
         pend_hi <= res_hi;
         pend_lo <= res_lo;
      end else if (idle_ok && op == MDU_MTHI) begin
         HI <= A;
      end else if (idle_ok && op == MDU_MTLO) begin
         LO <= A;
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: an edge-timestamp behavioural model checked every cycle,
// plus hand-computed literal results for each directed scenario.
module tb_mdu;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  MDUOp = 4'd0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        Start = 1'b0;
   logic        Req = 1'b0;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .MDUOp(MDUOp), .A(A), .B(B),
      .Start(Start), .Req(Req), .Busy(Busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nfail = 0;
   bit chk = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   bit          m_busy, p_wr;
   longint      cyc = 0;
   longint      m_done = 0;

   task automatic compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output bit wr, output logic [31:0] hi, output logic [31:0] lo);
      longint          sa, sb, ma, mb, q, r, p;
      longint unsigned ua, ub, up;
      wr = 1; hi = '0; lo = '0;
      sa = longint'($signed(a)); sb = longint'($signed(b));
      ua = longint'(a); ub = longint'(b);
      case (op)
         4'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
         4'd2: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
         4'd3: begin
            if (b == 0) wr = 0;
            else begin
               ma = (sa < 0) ? -sa : sa;
               mb = (sb < 0) ? -sb : sb;
               q = ma / mb; r = ma % mb;
               if ((sa < 0) != (sb < 0)) q = -q;
               if (sa < 0) r = -r;
               lo = q[31:0]; hi = r[31:0];
            end
         end
         4'd4: begin
            if (b == 0) wr = 0;
            else begin lo = a / b; hi = a % b; end
         end
         default: wr = 0;
      endcase
   endtask

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         m_hi = '0; m_lo = '0; m_busy = 0;
      end else if (m_busy) begin
         if (cyc == m_done) begin
            if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
            m_busy = 0;
         end
      end else if (!Req) begin
         if (Start && MDUOp >= 4'd1 && MDUOp <= 4'd4) begin
            compute(MDUOp, A, B, p_wr, p_hi, p_lo);
            m_busy = 1;
            m_done = cyc + ((MDUOp <= 4'd2) ? 5 : 10);
         end else if (MDUOp == 4'd5) m_hi = A;
         else if (MDUOp == 4'd6) m_lo = A;
      end
   end

   always @(posedge clk) begin
      #1;
      if (chk) begin
         check("busy", {31'b0, Busy}, {31'b0, m_busy});
         check("hi", HI, m_hi);
         check("lo", LO, m_lo);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      MDUOp = op; A = a; B = b; Start = (op >= 4'd1 && op <= 4'd4);
      @(negedge clk);
      MDUOp = 4'd0; Start = 1'b0; A = '0; B = '0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (Busy === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
   endtask

   int n;

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk = 1;
      check("rst_busy", {31'b0, Busy}, 32'd0);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);

      issue(4'd1, 32'hFFFF_FFFF, 32'd2);
      wait_idle(n);
      check("mult_len", n, 32'd5);
      check("mult_hi", HI, 32'hFFFF_FFFF);
      check("mult_lo", LO, 32'hFFFF_FFFE);

      issue(4'd2, 32'hFFFF_FFFF, 32'd2);
      wait_idle(n);
      check("multu_len", n, 32'd5);
      check("multu_hi", HI, 32'h0000_0001);
      check("multu_lo", LO, 32'hFFFF_FFFE);

      issue(4'd1, 32'hFFFF_FFFD, 32'hFFFF_FFF9);   // -3 * -7 = 21
      wait_idle(n);
      check("mult_nn_hi", HI, 32'd0);
      check("mult_nn_lo", LO, 32'd21);

      issue(4'd3, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      check("div_len", n, 32'd10);
      check("div_lo", LO, 32'hFFFF_FFFD);
      check("div_hi", HI, 32'hFFFF_FFFF);

      issue(4'd4, 32'd7, 32'd2);
      wait_idle(n);
      check("divu_lo", LO, 32'd3);
      check("divu_hi", HI, 32'd1);

      issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      check("divovf_lo", LO, 32'h8000_0000);
      check("divovf_hi", HI, 32'd0);

      issue(4'd3, 32'd7, 32'hFFFF_FFFE);           // 7 / -2 = -3 r 1
      wait_idle(n);
      check("divneg_lo", LO, 32'hFFFF_FFFD);
      check("divneg_hi", HI, 32'd1);

      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      issue(4'd5, 32'h1234_5678, 32'd0);
      check("mthi_hi", HI, 32'h1234_5678);
      check("mthi_busy", {31'b0, Busy}, 32'd0);
      issue(4'd6, 32'hCAFE_0001, 32'd0);
      check("mtlo_lo", LO, 32'hCAFE_0001);

      issue(4'd4, 32'd99, 32'd0);
      wait_idle(n);
      check("div0_len", n, 32'd10);
      check("div0_hi", HI, 32'h1234_5678);
      check("div0_lo", LO, 32'hCAFE_0001);

      @(negedge clk);
      MDUOp = 4'd1; Start = 1'b1; Req = 1'b1; A = 32'd3; B = 32'd4;
      @(negedge clk);
      MDUOp = 4'd0; Start = 1'b0; Req = 1'b0;
      check("req_busy", {31'b0, Busy}, 32'd0);
      repeat (6) @(negedge clk);
      check("req_hi", HI, 32'h1234_5678);
      check("req_lo", LO, 32'hCAFE_0001);

      // div in flight: flush, a stray start and a stray mthi must not disturb it
      issue(4'd3, 32'd100, 32'd7);
      n = 1;
      @(negedge clk); n = 2;
      @(negedge clk); n = 3;
      MDUOp = 4'd1; Start = 1'b1; Req = 1'b1; A = 32'd5; B = 32'd5;
      @(negedge clk); n = 4;
      MDUOp = 4'd5; Start = 1'b0; Req = 1'b0; A = 32'hDEAD_BEEF;
      @(negedge clk); n = 5;
      MDUOp = 4'd0; A = '0;
      while (Busy === 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("reqmid_len", n - 1, 32'd10);
      check("reqmid_lo", LO, 32'd14);
      check("reqmid_hi", HI, 32'd2);

      issue(4'd3, 32'd50, 32'd3);
      @(negedge clk);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      check("rstmid_busy", {31'b0, Busy}, 32'd0);
      check("rstmid_hi", HI, 32'd0);
      check("rstmid_lo", LO, 32'd0);
      repeat (12) @(negedge clk);
      check("rstmid_late_hi", HI, 32'd0);
      check("rstmid_late_lo", LO, 32'd0);

      issue(4'd7, 32'h1111_1111, 32'd1);
      @(negedge clk);
      check("nop_hi", HI, 32'd0);
      check("nop_busy", {31'b0, Busy}, 32'd0);

      chk = 0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the E stage of the five-stage MIPS pipeline; it sits beside the single-cycle ALU and owns the HI/LO register pair. It executes mult, multu, div, divu, mthi and mtlo. Multiply and divide take a fixed number of cycles, during which Busy is raised so that the hazard unit can stall dependent HI/LO instructions. The Req input cancels the instruction being issued when the E stage is flushed by an interrupt or exception.

## Interface
- MULT_CYCLES, 5: cycles for mult/multu from acceptance to HI/LO write.
- DIV_CYCLES, 10: cycles for div/divu from acceptance to HI/LO write.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- MDUOp  in  4  operation of the instruction in E; encoding is in the shared macro header.
- A  in  32  rs operand, already forwarded.
- B  in  32  rt operand, already forwarded.
- Start  in  1  asserted with MDUOp ∈ {MULT, MULTU, DIV, DIVU}.
- Req  in  1  flush request in this cycle; blocks issue.
- Busy  out  1  computation in flight.
- HI  out  32  architectural HI register, read directly by mfhi.
- LO  out  32  architectural LO register, read directly by mflo.

## Operation
- Issue condition: Start && !Req && !Busy at a rising edge.
  - On issue, compute the result from A and B, latch it into pending registers, and load the counter with MULT_CYCLES or DIV_CYCLES.
- Mult: {HI,LO} = signed A × signed B, full 64-bit product.
- Multu: {HI,LO} = unsigned A × unsigned B, full 64-bit product.
- Div (signed): quotient truncates toward zero.
  - LO = quotient.
  - HI = remainder; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divu: unsigned quotient to LO, remainder to HI.
- Divisor zero (div or divu): HI and LO are left unchanged, but Busy still runs the full DIV_CYCLES.
- Mthi: HI ← A at the edge when MDUOp==MTHI && !Req && !Busy. Mtlo: LO ← A under the same condition.
  - Neither affects Busy.
- Start while Busy, or mthi/mtlo while Busy: ignored. The stall logic guarantees these never occur; the unit must still not corrupt state if they do.
- Req never cancels a computation already accepted; that computation has committed.
- Any other MDUOp value: no effect.

## Timing
- Reset: HI=0, LO=0, Busy=0, counter=0, pending=0. No latched operation survives reset.
- Reset mid-operation aborts the operation: Busy falls after the reset edge and HI/LO read 0.
- Issue at edge t0 with latency N:
  - Busy=1 for cycles t0+1 through t0+N.
  - At edge t0+N, HI/LO are written and Busy goes to 0.
  - New HI/LO values are visible from cycle t0+N+1.
- The counter decrements every cycle while nonzero; the write happens on the edge where the counter equals 1.
- Busy is registered. The hazard unit stalls mult/div/mfhi/mflo/mthi/mtlo in E while (Start|Busy).
  - Start is therefore counted as busy the cycle before Busy rises.
- Mthi/mtlo latency: one edge; the value is readable on HI/LO the next cycle.
- Back-to-back issue: a new Start may be accepted in cycle t0+N+1 at the earliest.

## Structure
- Shared macro header holds:
  - MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6.
  - Default cycle counts MDU_MULT_CYCLES=5 and MDU_DIV_CYCLES=10.
- The unit is a single module, mdu.
  - Results are computed with behavioural * / % on issue and held in pending registers.
  - There is no iterative divider sub-module.
- The counter is 4 bits wide, enough for DIV_CYCLES ≤ 15.

## Test plan
- Mult, A=0xFFFFFFFF, B=2 → Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- Multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- Div, A=0xFFFFFFF9 (−7), B=2 → Busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Divu, A=7, B=2 → LO=3, HI=1.
- Mthi A=0x12345678 with HI=0 → HI=0x12345678 next cycle, Busy stays 0.
  - Then divu with B=0 → Busy 10 cycles, HI/LO unchanged.
- Start of mult with Req=1 → Busy never rises, HI/LO unchanged.
  - Req=1 during cycle 3 of a running div → the div still completes at cycle 10.
- Reset asserted during cycle 3 of a div → Busy=0 and HI=LO=0 after the edge; no write occurs at the old completion cycle.
